cache_wb_buffer: RTL and testbench
==================================

Name: cache_wb_buffer

Overview:
- Writeback buffer directly downstream of the cache bank data stage.
- Captures evicted or flushed dirty lines (line address, line data, per-byte dirty mask) produced on flush/replacement fills.
- Queues them in a small FIFO and drains them to the bank's memory request port with a valid/ready handshake.
- Exposes an address-match lookup so the bank can hold a miss whose line is still pending writeback (read-after-evict hazard).

Parameters:
- LINE_SIZE, 16, line size in bytes.
- LINE_ADDR_WIDTH, 26, bank line-address width.
- DEPTH, 4, number of entries; power of two, >= 2.
- DIRTY_BYTES, 0, 1 = honour evict_byteen; 0 = treat every enqueued line as fully dirty.
- BANK_ID, 0, bank index, used for trace only.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- evict_valid  in  1  dirty line presented by data stage.
- evict_ready  out  1  buffer can accept this cycle.
- evict_addr  in  LINE_ADDR_WIDTH  line address of victim.
- evict_data  in  LINE_SIZE*8  victim line data.
- evict_byteen  in  LINE_SIZE  dirty byte mask.
- mem_req_valid  out  1  head entry valid toward memory.
- mem_req_ready  in  1  memory accepts.
- mem_req_addr  out  LINE_ADDR_WIDTH  head line address.
- mem_req_data  out  LINE_SIZE*8  head line data.
- mem_req_byteen  out  LINE_SIZE  head byte mask.
- lookup_addr  in  LINE_ADDR_WIDTH  address probed by tag stage.
- lookup_hit  out  1  probed line is pending in buffer.
- empty  out  1  no pending entries (used by flush-complete logic).
- full  out  1  all DEPTH entries occupied.

Behaviour:
- Reset (reset==0): rd/wr pointers = 0, count = 0, all entry-valid bits = 0. Outputs: mem_req_valid=0, lookup_hit=0, empty=1, full=0, evict_ready=1. Data/addr outputs are don't-care but deterministic (0). Reset mid-drain drops all pending entries; no request is reissued.
- Storage:
  - Circular FIFO with log2(DEPTH)+1-bit count; pointers wrap modulo DEPTH.
  - Each entry holds {valid, addr, data, byteen}.
- Enqueue:
  - Fires when evict_valid && evict_ready.
  - evict_ready = !full; it does not depend on mem_req_ready, so there is no combinational ready path.
  - DIRTY_BYTES=1 with evict_byteen==0: handshake completes but nothing is stored (clean line dropped), count unchanged.
  - DIRTY_BYTES=0: stored byteen is forced to all ones.
- Latency: a line enqueued at cycle N appears on mem_req_* at N+1 if the buffer was empty. mem_req_* are driven from entry registers, with no logic after the mux.
- Dequeue:
  - Fires when mem_req_valid && mem_req_ready; head pointer advances and the entry valid bit clears.
  - mem_req_* hold stable while valid && !ready.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Full + dequeue: evict_ready stays 0 that cycle; the slot frees next cycle.
  - Empty + enqueue: no bypass; the entry is visible next cycle.
- Lookup:
  - Combinational: lookup_hit = OR over valid entries of (addr == lookup_addr).
  - Does not see an enqueue in the same cycle.
  - Still asserts for the head entry during the cycle it is being dequeued.
- Status flags: empty = (count==0); full = (count==DEPTH), both registered-derived.
- Ordering: strict FIFO. Two evictions of the same address are both kept, in order.
- Assertions (simulation):
  - No enqueue when full.
  - mem_req_* stable under backpressure.
  - count never exceeds DEPTH.
- Trace: under DBG_TRACE_CACHE, each enqueue and dequeue is printed with addr and byteen.

Decomposition:
- Shared cache package: LINE_ADDR_WIDTH/LINE_WIDTH derivations and the writeback entry struct {addr, data, byteen}.
- One sub-module: cache_wb_fifo_ctrl, holding pointers, count, full/empty and the valid-bit vector.
- The top level holds the entry register array, the head mux and the lookup comparators.

Test Plan:
- Reset held low for 3 cycles with evict_valid=1 -> evict_ready=1, but nothing is stored after release: empty=1, mem_req_valid=0.
- Enqueue addr 0x10, byteen 0xFFFF, mem_req_ready=1 -> mem_req_valid high exactly 1 cycle later with addr 0x10; empty=1 the cycle after acceptance.
- mem_req_ready=0, enqueue 0x1..0x4 (DEPTH=4) -> full=1, evict_ready=0, 5th evict held. Raise ready -> drains 0x1,0x2,0x3,0x4 in order, 5th accepted the cycle after the first dequeue.
- Buffer holds 0x20 and 0x21: lookup_addr=0x21 -> hit=1; lookup_addr=0x22 -> hit=0. After 0x21 drains, lookup 0x21 -> hit=0.
- DIRTY_BYTES=1, evict byteen=0x0000 -> evict_ready=1, count stays 0, no mem request. DIRTY_BYTES=0, byteen=0x0003 -> mem_req_byteen=0xFFFF.
- Count=2, simultaneous enqueue and dequeue every cycle for 20 cycles with random addresses -> count stays 2 and output order matches a scoreboard.

Source files
------------

// File: rtl/cache_wb_buffer_pkg.sv
// Shared cache definitions for the writeback buffer.
// Line geometry and the queued writeback entry layout.
package cache_wb_buffer_pkg;

  localparam int WB_LINE_SIZE       = 16;
  localparam int WB_LINE_ADDR_WIDTH = 26;
  localparam int WB_LINE_WIDTH      = WB_LINE_SIZE * 8;

  typedef struct packed {
    logic [WB_LINE_ADDR_WIDTH-1:0] addr;
    logic [WB_LINE_WIDTH-1:0]      data;
    logic [WB_LINE_SIZE-1:0]       byteen;
  } wb_entry_t;

endpackage

// File: rtl/cache_wb_fifo_ctrl.sv
// Writeback FIFO bookkeeping: pointers, occupancy,
// full/empty flags and the per-entry valid vector.
module cache_wb_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [PW-1:0]    o_wr_ptr,
  output logic [PW-1:0]    o_rd_ptr,
  output logic [DEPTH-1:0] o_valid,
  output logic             o_empty,
  output logic             o_full
);

  localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_nxt;

  always_comb begin
    w_valid_nxt = r_valid;
    if (i_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
    if (i_push) w_valid_nxt[r_wr_ptr] = 1'b1;
  end

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_valid  = r_valid;
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_FULL);

  a_count_bound: assert property (
    @(posedge clk) disable iff (!reset)
    r_count <= CNT_FULL);

endmodule

// File: rtl/cache_wb_buffer.sv
// Cache bank writeback buffer: queues dirty victims, drains
// them to memory in order, and flags read-after-evict hits.
module cache_wb_buffer
  import cache_wb_buffer_pkg::*;
#(
  parameter int LINE_SIZE       = WB_LINE_SIZE,
  parameter int LINE_ADDR_WIDTH = WB_LINE_ADDR_WIDTH,
  parameter int DEPTH           = 4,
  parameter int DIRTY_BYTES     = 0,
  parameter int BANK_ID         = 0,
  localparam int LW             = LINE_SIZE * 8,
  localparam int PW             = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       evict_valid,
  output logic                       evict_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] evict_addr,
  input  logic [LW-1:0]              evict_data,
  input  logic [LINE_SIZE-1:0]       evict_byteen,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LW-1:0]              mem_req_data,
  output logic [LINE_SIZE-1:0]       mem_req_byteen,
  input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr,
  output logic                       lookup_hit,
  output logic                       empty,
  output logic                       full
);

  if (LINE_SIZE != WB_LINE_SIZE ||
      LINE_ADDR_WIDTH != WB_LINE_ADDR_WIDTH ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      BANK_ID < 0) begin : g_bad_cfg
    $error("cache_wb_buffer: unsupported geometry");
  end

  wb_entry_t        r_mem [DEPTH];
  wb_entry_t        w_in;
  wb_entry_t        w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_dirty;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic [DEPTH-1:0] w_valid;
  logic             w_empty;
  logic             w_full;

  cache_wb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_valid  (w_valid),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  // A clean victim still handshakes; it is simply not stored.
  assign w_dirty     = (DIRTY_BYTES == 0) || (|evict_byteen);
  assign evict_ready = !w_full;
  assign w_push      = evict_valid && evict_ready && w_dirty;
  assign w_pop       = mem_req_valid && mem_req_ready;

  always_comb begin
    w_in.addr   = evict_addr;
    w_in.data   = evict_data;
    w_in.byteen = (DIRTY_BYTES == 0) ? '1 : evict_byteen;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= w_in;
    end
  end

  assign w_head         = r_mem[w_rd_ptr];
  assign mem_req_valid  = !w_empty;
  assign mem_req_addr   = w_head.addr;
  assign mem_req_data   = w_head.data;
  assign mem_req_byteen = w_head.byteen;
  assign empty          = w_empty;
  assign full           = w_full;

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && r_mem[i].addr == lookup_addr)
        lookup_hit = 1'b1;
    end
  end

  a_no_enq_full: assert property (
    @(posedge clk) disable iff (!reset)
    w_full |-> !w_push);

  a_req_stable: assert property (
    @(posedge clk) disable iff (!reset)
    mem_req_valid && !mem_req_ready |=>
      mem_req_valid &&
      $stable({mem_req_addr, mem_req_data, mem_req_byteen}));

`ifdef DBG_TRACE_CACHE
  always_ff @(posedge clk) begin
    if (reset && w_push)
      $display("wb%0d enq addr=%h be=%h",
               BANK_ID, w_in.addr, w_in.byteen);
    if (reset && w_pop)
      $display("wb%0d deq addr=%h be=%h",
               BANK_ID, mem_req_addr, mem_req_byteen);
  end
`endif

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Bench for cache_wb_buffer: two instances (byte-mask honoured
// and ignored) checked against a queue model plus a lookup table.
module tb_cache_wb_buffer;

  localparam int LS = 16;
  localparam int AW = 26;
  localparam int LW = LS * 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ev_valid;
  logic [AW-1:0] ev_addr;
  logic [LW-1:0] ev_data;
  logic [LS-1:0] ev_be;
  logic          mrdy;
  logic [AW-1:0] lk_addr;

  logic          er  [2];
  logic          mv  [2];
  logic [AW-1:0] ma  [2];
  logic [LW-1:0] md  [2];
  logic [LS-1:0] mb  [2];
  logic          hit [2];
  logic          emp [2];
  logic          ful [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_wb_buffer #(.DEPTH(D), .DIRTY_BYTES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .evict_valid(ev_valid), .evict_ready(er[0]),
    .evict_addr(ev_addr), .evict_data(ev_data),
    .evict_byteen(ev_be),
    .mem_req_valid(mv[0]), .mem_req_ready(mrdy),
    .mem_req_addr(ma[0]), .mem_req_data(md[0]),
    .mem_req_byteen(mb[0]),
    .lookup_addr(lk_addr), .lookup_hit(hit[0]),
    .empty(emp[0]), .full(ful[0])
  );

  cache_wb_buffer #(.DEPTH(D), .DIRTY_BYTES(1), .BANK_ID(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .evict_valid(ev_valid), .evict_ready(er[1]),
    .evict_addr(ev_addr), .evict_data(ev_data),
    .evict_byteen(ev_be),
    .mem_req_valid(mv[1]), .mem_req_ready(mrdy),
    .mem_req_addr(ma[1]), .mem_req_data(md[1]),
    .mem_req_byteen(mb[1]),
    .lookup_addr(lk_addr), .lookup_hit(hit[1]),
    .empty(emp[1]), .full(ful[1])
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [LS-1:0] b;
  } ent_t;

  // Pending lines, oldest first, one queue per instance.
  ent_t q0[$];
  ent_t q1[$];

  function automatic void chk(string nm, int k,
                              logic [LW-1:0] act,
                              logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endfunction

  task automatic check_dut(input int k);
    ent_t q[$];
    logic h;
    if (k == 0) q = q0;
    else        q = q1;
    h = 1'b0;
    foreach (q[i]) if (q[i].a == lk_addr) h = 1'b1;
    chk("evict_ready", k, LW'(er[k]),  LW'(q.size() < D));
    chk("mem_valid",   k, LW'(mv[k]),  LW'(q.size() != 0));
    chk("lookup_hit",  k, LW'(hit[k]), LW'(h));
    chk("empty",       k, LW'(emp[k]), LW'(q.size() == 0));
    chk("full",        k, LW'(ful[k]), LW'(q.size() == D));
    if (q.size() != 0) begin
      chk("mem_addr",   k, LW'(ma[k]), LW'(q[0].a));
      chk("mem_data",   k, md[k],      q[0].d);
      chk("mem_byteen", k, LW'(mb[k]), LW'(q[0].b));
    end
  endtask

  // Model update from the pre-edge occupancy of each queue.
  task automatic model_edge();
    bit acc0, acc1, pop0, pop1;
    if (!reset) begin
      q0.delete();
      q1.delete();
      return;
    end
    acc0 = ev_valid && (q0.size() < D);
    acc1 = ev_valid && (q1.size() < D);
    pop0 = mrdy && (q0.size() != 0);
    pop1 = mrdy && (q1.size() != 0);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (acc0) q0.push_back('{a: ev_addr, d: ev_data, b: '1});
    if (acc1 && ev_be != '0)
      q1.push_back('{a: ev_addr, d: ev_data, b: ev_be});
  endtask

  task automatic chk_edge();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    chk_edge();
    adv();
  endtask

  task automatic evict(input logic v, input logic [AW-1:0] a,
                       input logic [LS-1:0] be);
    ev_valid = v;
    ev_addr  = a;
    ev_be    = be;
    ev_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic          rdy;
    logic [AW-1:0] lk;
    logic          hit;
    logic          emp;
    logic          mv;
    logic [AW-1:0] ma;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 26'h20, 1'b0, 26'h20, 1'b0, 1'b1, 1'b0, 26'h0};
    tbl[1] = '{1'b1, 26'h21, 1'b0, 26'h20, 1'b1, 1'b0, 1'b1, 26'h20};
    tbl[2] = '{1'b0, 26'h0,  1'b0, 26'h21, 1'b1, 1'b0, 1'b1, 26'h20};
    tbl[3] = '{1'b0, 26'h0,  1'b0, 26'h22, 1'b0, 1'b0, 1'b1, 26'h20};
    tbl[4] = '{1'b0, 26'h0,  1'b1, 26'h20, 1'b1, 1'b0, 1'b1, 26'h20};
    tbl[5] = '{1'b0, 26'h0,  1'b1, 26'h21, 1'b1, 1'b0, 1'b1, 26'h21};
    tbl[6] = '{1'b0, 26'h0,  1'b1, 26'h21, 1'b0, 1'b1, 1'b0, 26'h0};

    reset   = 1'b0;
    mrdy    = 1'b0;
    lk_addr = '0;
    evict(1'b0, '0, '0);
    @(posedge clk);
    #1;

    // Reset held with a victim presented: nothing may be kept.
    evict(1'b1, 26'h5, 16'hFFFF);
    repeat (3) tick();
    reset = 1'b1;
    evict(1'b0, '0, '0);
    tick();
    tick();

    // Single line: visible one cycle after acceptance.
    mrdy = 1'b1;
    evict(1'b1, 26'h10, 16'hFFFF);
    lk_addr = 26'h10;
    tick();
    evict(1'b0, '0, '0);
    tick();
    tick();

    // Fill under backpressure, hold a fifth, then drain in order.
    mrdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      evict(1'b1, AW'(i), 16'hFFFF);
      tick();
    end
    evict(1'b1, 26'h5, 16'hFFFF);
    tick();
    tick();
    mrdy = 1'b1;
    tick();
    tick();
    evict(1'b0, '0, '0);
    repeat (6) tick();

    // Lookup table, both instances.
    for (int i = 0; i < 7; i++) begin
      evict(tbl[i].v, tbl[i].a, 16'hFFFF);
      mrdy    = tbl[i].rdy;
      lk_addr = tbl[i].lk;
      chk_edge();
      for (int k = 0; k < 2; k++) begin
        chk("tbl_hit",   k, LW'(hit[k]), LW'(tbl[i].hit));
        chk("tbl_empty", k, LW'(emp[k]), LW'(tbl[i].emp));
        chk("tbl_valid", k, LW'(mv[k]),  LW'(tbl[i].mv));
        if (tbl[i].mv)
          chk("tbl_addr", k, LW'(ma[k]), LW'(tbl[i].ma));
      end
      adv();
    end

    // Clean and partially dirty victims.
    mrdy = 1'b0;
    evict(1'b1, 26'h30, 16'h0000);
    tick();
    evict(1'b1, 26'h31, 16'h0003);
    tick();
    evict(1'b0, '0, '0);
    chk_edge();
    chk("clean_drop_empty", 1, LW'(emp[1]), LW'(1'b0));
    chk("partial_be", 1, LW'(mb[1]), LW'(16'h0003));
    chk("forced_be",  0, LW'(mb[0]), LW'(16'hFFFF));
    adv();
    mrdy = 1'b1;
    repeat (3) tick();

    // Steady occupancy of two with enqueue+dequeue every cycle.
    mrdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      evict(1'b1, AW'($urandom), 16'hFFFF);
      tick();
    end
    mrdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      evict(1'b1, AW'($urandom), 16'hFFFF);
      lk_addr = ev_addr;
      tick();
    end
    evict(1'b0, '0, '0);
    repeat (3) tick();

    // Reset in the middle of a drain drops everything.
    mrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      evict(1'b1, AW'(8'h40 + i), 16'hFFFF);
      tick();
    end
    evict(1'b0, '0, '0);
    mrdy = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Random traffic over a small address pool.
    for (int i = 0; i < 500; i++) begin
      evict(1'($urandom), AW'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? '0 : LS'($urandom));
      mrdy    = 1'($urandom);
      lk_addr = AW'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
